// File: rtl/seq_detect_moore_param.sv
// ----------------------------------------------------------------------------
// seq_detect_moore_param
//   Parametrised Moore serial sequence detector. Watches a 1-bit stream
//   qualified by in_valid and flags every occurrence of a programmable
//   PAT_LEN-bit pattern (MSB = oldest bit). Overlapping or non-overlapping
//   matching is fixed at build time; detections are counted in a saturating
//   counter.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (overrides everything)
//   in_valid   qualifies `in`
//   in         serial data bit
//   load       one-cycle strobe: take pat_in as the new pattern, restart FSM
//   pat_in     new pattern, MSB first
//   clr_cnt    clear match_cnt (wins over a coincident increment)
//   det        high while the FSM is in DETECT (registered)
//   match_cnt  saturating count of DETECT entries
//   state_o    current FSM state for debug (S0..S(PAT_LEN-1), DETECT=PAT_LEN)
// ----------------------------------------------------------------------------
module seq_detect_moore_param #(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in,
    input  logic                           load,
    input  logic [PAT_LEN-1:0]             pat_in,
    input  logic                           clr_cnt,
    output logic                           det,
    output logic [CNT_W-1:0]               match_cnt,
    output logic [$clog2(PAT_LEN+1)-1:0]   state_o
);

    localparam int unsigned SW = $clog2(PAT_LEN + 1);

    // Intermediate states Sk are reached by casting the prefix length k.
    typedef enum logic [SW-1:0] {
        ST_S0     = '0,
        ST_DETECT = SW'(PAT_LEN)
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_LEN-1:0] pat_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               det_q;
    logic               hit;

    int unsigned        keff;
    logic [SW-1:0]      best;
    logic [PAT_LEN:0]   hist_v;
    logic [PAT_LEN:0]   pre_v;
    logic [PAT_LEN:0]   mask_v;

    // Next-state search. In state Sk the last k accepted bits are, by
    // definition, the first k pattern bits, so the history string is rebuilt
    // from the pattern register itself: {pattern[MSB -: k], in}. The longest
    // suffix of that string equal to a pattern prefix is the next state,
    // which is exact (KMP-equivalent) for any pattern, including runtime
    // loads. Non-overlap DETECT starts from an empty history (k = 0).
    always_comb begin
        keff = 0;
        if (state_q == ST_DETECT) begin
            keff = OVERLAP ? PAT_LEN : 0;
        end else begin
            keff = 32'(state_q);
        end

        hist_v = {1'b0, pat_q} >> (PAT_LEN - keff);
        hist_v = {hist_v[PAT_LEN-1:0], in};

        best   = '0;
        pre_v  = '0;
        mask_v = '0;
        for (int unsigned j = 1; j <= PAT_LEN; j++) begin
            mask_v = ~({(PAT_LEN+1){1'b1}} << j);
            pre_v  = {1'b0, pat_q} >> (PAT_LEN - j);
            if ((j <= keff + 1) && ((hist_v & mask_v) == pre_v)) begin
                best = SW'(j);
            end
        end

        state_d = state_t'(best);
        hit     = in_valid && !load && (state_d == ST_DETECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= PATTERN;
            state_q <= ST_S0;
            det_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // A bit presented alongside load is discarded.
            if (load) begin
                pat_q   <= pat_in;
                state_q <= ST_S0;
                det_q   <= 1'b0;
            end else if (in_valid) begin
                state_q <= state_d;
                det_q   <= (state_d == ST_DETECT);
            end

            if (clr_cnt) begin
                cnt_q <= '0;
            end else if (hit && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign det       = det_q;
    assign match_cnt = cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// ----------------------------------------------------------------------------
// tb_seq_detect_moore_param
//   Drives three detector builds with the same stimulus: overlap/8-bit count,
//   non-overlap/8-bit count and overlap/2-bit count. A reference model keeps
//   the recent accepted bits as a plain integer plus a length and recomputes
//   the matched-prefix length by brute-force suffix/prefix comparison.
// ----------------------------------------------------------------------------
module tb_seq_detect_moore_param;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_b, load, clr_cnt;
    logic [3:0] pat_in;

    logic       det0, det1, det2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic [2:0] st0, st1, st2;

    seq_detect_moore_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_b), .load(load), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .det(det0), .match_cnt(cnt0), .state_o(st0));

    seq_detect_moore_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_b), .load(load), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .det(det1), .match_cnt(cnt1), .state_o(st1));

    seq_detect_moore_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_b), .load(load), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .det(det2), .match_cnt(cnt2), .state_o(st2));

    int          checks   = 0;
    int          failures = 0;

    // Reference model state, one slot per instance.
    logic [3:0]  mpat;
    int unsigned hbits[3];
    int unsigned hlen[3];
    int unsigned mcnt[3];
    bit          mdet[3];

    function automatic bit ovl(input int i);
        return (i != 1);
    endfunction

    function automatic int unsigned cmax(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    // Longest j such that the last j accepted bits equal the first j pattern bits.
    function automatic int unsigned longest(input int i);
        for (int j = 4; j >= 1; j--) begin
            if (j <= int'(hlen[i]) &&
                (hbits[i] & ((32'd1 << j) - 1)) == (32'(mpat) >> (4 - j)))
                return j;
        end
        return 0;
    endfunction

    function automatic int unsigned exp_state(input int i);
        return mdet[i] ? 4 : longest(i);
    endfunction

    task automatic model_reset();
        mpat = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            hbits[i] = 0; hlen[i] = 0; mcnt[i] = 0; mdet[i] = 1'b0;
        end
    endtask

    task automatic model_accept(input logic b);
        for (int i = 0; i < 3; i++) begin
            hbits[i] = ((hbits[i] << 1) | 32'(b)) & 32'hF;
            hlen[i]  = (hlen[i] < 4) ? hlen[i] + 1 : 4;
            if (longest(i) == 4) begin
                mdet[i] = 1'b1;
                if (mcnt[i] < cmax(i)) mcnt[i]++;
                if (!ovl(i)) hlen[i] = 0;
            end else begin
                mdet[i] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input int unsigned exp);
        checks++;
        assert (got === 32'(exp)) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("ov_det",  32'(det0), 32'(mdet[0]));
        chk("ov_cnt",  32'(cnt0), mcnt[0]);
        chk("ov_st",   32'(st0),  exp_state(0));
        chk("no_det",  32'(det1), 32'(mdet[1]));
        chk("no_cnt",  32'(cnt1), mcnt[1]);
        chk("no_st",   32'(st1),  exp_state(1));
        chk("sat_det", 32'(det2), 32'(mdet[2]));
        chk("sat_cnt", 32'(cnt2), mcnt[2]);
        chk("sat_st",  32'(st2),  exp_state(2));
    endtask

    // One clock: drive inputs, advance model at the edge, check 1 time unit later.
    task automatic step(input logic r, input logic v, input logic b,
                        input logic ld, input logic [3:0] p, input logic clr);
        rst = r; in_valid = v; in_b = b; load = ld; pat_in = p; clr_cnt = clr;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (ld) begin
                mpat = p;
                for (int i = 0; i < 3; i++) begin
                    hlen[i] = 0; mdet[i] = 1'b0;
                end
            end else if (v) begin
                model_accept(b);
            end
            if (clr) begin
                for (int i = 0; i < 3; i++) mcnt[i] = 0;
            end
        end
        #1;
        check_all();
    endtask

    task automatic send(input logic [31:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) step(1'b0, 1'b1, bits[k], 1'b0, 4'b0000, 1'b0);
    endtask

    initial begin
        model_reset();
        rst = 1'b1; in_valid = 1'b0; in_b = 1'b0; load = 1'b0; pat_in = 4'b0000; clr_cnt = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
        chk("rst_det", 32'(det0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_st",  32'(st0),  0);

        // Overlap vs non-overlap: 1,0,1,1,0,1,1
        send(32'b1011, 4);
        chk("d4_ov_det", 32'(det0), 1);
        chk("d4_no_det", 32'(det1), 1);
        send(32'b0, 1);
        chk("b5_ov_st", 32'(st0), 2);
        send(32'b11, 2);
        chk("d7_ov_det", 32'(det0), 1);
        chk("d7_ov_cnt", 32'(cnt0), 2);
        chk("d7_no_det", 32'(det1), 0);
        chk("d7_no_cnt", 32'(cnt1), 1);

        // Stall: det held through in_valid=0, drops after the next accepted 0
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        send(32'b1011, 4);
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
            chk("stall_det", 32'(det0), 1);
        end
        send(32'b0, 1);
        chk("stall_drop", 32'(det0), 0);
        chk("stall_cnt",  32'(cnt0), 1);

        // Runtime load with a discarded bit, then 0110
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
        chk("load_st", 32'(st0), 0);
        send(32'b011, 3);
        chk("load_nodet", 32'(det0), 0);
        send(32'b0, 1);
        chk("load_det", 32'(det0), 1);

        // Pattern 1111 under overlap: five 1s give two entries
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
        send(32'b1111, 4);
        chk("p1111_d4", 32'(det0), 1);
        send(32'b1, 1);
        chk("p1111_d5",    32'(det0), 1);
        chk("p1111_cnt",   32'(cnt0), 4);
        chk("p1111_no_d5", 32'(det1), 0);
        chk("sat_hold",    32'(cnt2), 3);

        // Saturation with CNT_W=2, then clear coinciding with a match entry
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        for (int m = 0; m < 5; m++) send(32'b1011, 4);
        chk("sat_cnt3", 32'(cnt2), 3);
        send(32'b101, 3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        chk("clr_det", 32'(det2), 1);
        chk("clr_cnt", 32'(cnt2), 0);

        // Reset mid-stream loses partial progress
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        send(32'b101, 3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        chk("mrst_det", 32'(det0), 0);
        send(32'b011, 3);
        chk("mrst_nodet", 32'(det0), 0);
        send(32'b1011, 4);
        chk("mrst_det2", 32'(det0), 1);
        chk("mrst_cnt",  32'(cnt0), 1);

        // Randomised traffic with occasional loads, clears, resets and stalls
        for (int n = 0; n < 1500; n++) begin
            logic       r, v, b, ld, c;
            logic [3:0] p;
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 59) == 0);
            c  = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 9) < 8);
            b  = 1'($urandom_range(0, 1));
            p  = 4'($urandom_range(0, 15));
            step(r, v, b, ld, p, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
